tlc_timer: RTL and testbench

Countdown datapath paired with the traffic-light controller. It loads a phase duration in seconds when the controller pulses `dp_rst` and counts down once per second using a clock prescaler. It asserts `cnt_done` when the duration expires and drives the remaining-seconds value as BCD and seven-segment digits for the pedestrian countdown display. It sits directly downstream of the controller's `dp_rst`/`dp_value` outputs and feeds `cnt_done` back to it.

---
 rtl/tlc_pkg.sv | 47 ++++
 rtl/tlc_bin2bcd.sv | 39 +++
 rtl/tlc_timer.sv | 91 +++++++++
 tb/tb_tlc_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller and its countdown timer:
// count width, default prescaler, phase durations and seven-segment patterns.
package tlc_pkg;

  // Width of dp_value / count; the controller drives dp_value at this width.
  localparam int CNT_W        = 5;
  // One-second tick at a 50 MHz system clock.
  localparam int TICK_DIV_DEF = 50_000_000;

  // Phase durations in seconds, shared with the controller.
  localparam int T_RED = 28;
  localparam int T_YEL = 3;
  localparam int T_GRN = 28;

  // Active-high segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Decimal digit to segment pattern; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tlc_bin2bcd.sv
// Combinational binary (0..31) to two-digit BCD plus seven-segment decode
// for the pedestrian countdown display. Tens digit is blanked when zero.
module tlc_bin2bcd #(
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0] bin_i,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o,
  output logic [6:0]       seg_tens_o,
  output logic [6:0]       seg_ones_o
);
  import tlc_pkg::*;

  logic [CNT_W-1:0] rem;

  // Compare-subtract chain: peel off the largest multiple of ten first.
  always_comb begin
    rem    = bin_i;
    tens_o = 4'd0;
    if (rem >= CNT_W'(30)) begin
      tens_o = 4'd3;
      rem    = rem - CNT_W'(30);
    end else if (rem >= CNT_W'(20)) begin
      tens_o = 4'd2;
      rem    = rem - CNT_W'(20);
    end else if (rem >= CNT_W'(10)) begin
      tens_o = 4'd1;
      rem    = rem - CNT_W'(10);
    end
    ones_o = 4'(rem);
  end

  // Segment decode; a leading zero on the tens digit is suppressed.
  always_comb begin
    seg_tens_o = (tens_o == 4'd0) ? SEG_BLANK : seg_decode(tens_o);
    seg_ones_o = seg_decode(ones_o);
  end

endmodule

// File: rtl/tlc_timer.sv
// Phase countdown timer for the traffic-light controller. A load strobe
// (dp_rst) captures the phase duration; a prescaler produces one tick per
// second and the count decrements on each tick until it reaches zero, where
// cnt_done is raised and held until the next load.
module tlc_timer #(
  parameter int TICK_DIV = tlc_pkg::TICK_DIV_DEF,
  parameter int CNT_W    = tlc_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dp_rst,
  input  logic [CNT_W-1:0] dp_value,
  input  logic             pause,
  output logic             cnt_done,
  output logic             sec_tick,
  output logic [CNT_W-1:0] remaining,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_ones
);
  import tlc_pkg::*;

  // TICK_DIV must be at least 2 so the prescaler has a distinct wrap value.
  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q,  done_d;
  logic             tick_q,  tick_d;

  // Next state: load beats pause, tick and done; pause freezes everything
  // except that the tick pulse drops.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    if (dp_rst) begin
      presc_d = '0;
      count_d = dp_value;
      done_d  = (dp_value == '0);
    end else if (!pause) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // Count saturates at zero; the last decrement raises done.
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1))
            done_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers; reset clears everything and the block stays idle
  // (count 0, done 0) until the controller issues a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  assign cnt_done  = done_q;
  assign sec_tick  = tick_q;
  assign remaining = count_q;

  // Display digits follow the count with no added latency.
  tlc_bin2bcd #(
    .CNT_W (CNT_W)
  ) u_bcd (
    .bin_i      (count_q),
    .tens_o     (bcd_tens),
    .ones_o     (bcd_ones),
    .seg_tens_o (seg_tens),
    .seg_ones_o (seg_ones)
  );

endmodule

// File: tb/tb_tlc_timer.sv
// Scoreboard bench for tlc_timer with TICK_DIV=4. Stimulus pushes expected
// output snapshots tagged with a cycle number; the monitor compares them on
// the falling edge of that cycle.
module tb_tlc_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dp_rst = 1'b0;
  logic [4:0] dp_value = 5'd0;
  logic       pause = 1'b0;
  logic       cnt_done, sec_tick;
  logic [4:0] remaining;
  logic [3:0] bcd_tens, bcd_ones;
  logic [6:0] seg_tens, seg_ones;

  tlc_timer #(.TICK_DIV(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .dp_rst(dp_rst), .dp_value(dp_value), .pause(pause),
    .cnt_done(cnt_done), .sec_tick(sec_tick), .remaining(remaining),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .seg_tens(seg_tens), .seg_ones(seg_ones)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] rem;
    logic       done;
    logic       tick;
    logic [3:0] bt;
    logic [3:0] bo;
    logic [6:0] st;
    logic [6:0] so;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Hand-written segment table, bit 0 = a.
  function automatic logic [6:0] tseg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  task automatic push(input int c, input logic [4:0] r, input logic d,
                      input logic t, input logic [3:0] bt, input logic [3:0] bo);
    exp_t e;
    e.cyc = c; e.rem = r; e.done = d; e.tick = t; e.bt = bt; e.bo = bo;
    e.st  = (bt == 4'd0) ? 7'h00 : tseg(bt);
    e.so  = tseg(bo);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  // Monitor: compare every snapshot due at or before this cycle.
  exp_t        me;
  logic [28:0] m_got, m_exp;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me    = q.pop_front();
      m_got = {remaining, cnt_done, sec_tick, bcd_tens, bcd_ones, seg_tens, seg_ones};
      m_exp = {me.rem, me.done, me.tick, me.bt, me.bo, me.st, me.so};
      n_chk++;
      if (me.cyc != cyc || m_got !== m_exp) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d (due %0d) got rem=%0d done=%b tick=%b bcd=%0d%0d seg=%h/%h expected rem=%0d done=%b tick=%b bcd=%0d%0d seg=%h/%h",
                 cyc, me.cyc, remaining, cnt_done, sec_tick, bcd_tens, bcd_ones,
                 seg_tens, seg_ones, me.rem, me.done, me.tick, me.bt, me.bo, me.st, me.so);
      end
    end
  end

  // Rising edges of cnt_done, for the closed-loop check.
  int   done_rises = 0;
  logic done_prev  = 1'b0;
  always @(negedge clk) begin
    done_prev <= cnt_done;
    if (cnt_done && !done_prev) done_rises <= done_rises + 1;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // One-cycle load strobe; c0 is the cycle in which the load is visible.
  task automatic do_load(input logic [4:0] v, input logic p, output int c0);
    dp_rst   = 1'b1;
    dp_value = v;
    pause    = p;
    c0       = cyc + 1;
    @(posedge clk); #1;
    dp_rst   = 1'b0;
  endtask

  int c0, c1, rr, ticks, n, r0;
  int durs[3] = '{28, 3, 28};

  initial begin
    // Reset held from time zero, then an idle tick with nothing loaded.
    push(2, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    wait_cyc(4);
    rst = 1'b1;
    push(7, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    push(8, 5'd0, 1'b0, 1'b1, 4'd0, 4'd0);
    wait_cyc(10);

    // Basic countdown from 3.
    do_load(5'd3, 1'b0, c0);
    push(c0,      5'd3, 1'b0, 1'b0, 4'd0, 4'd3);
    push(c0 + 1,  5'd3, 1'b0, 1'b0, 4'd0, 4'd3);
    push(c0 + 4,  5'd2, 1'b0, 1'b1, 4'd0, 4'd2);
    push(c0 + 5,  5'd2, 1'b0, 1'b0, 4'd0, 4'd2);
    push(c0 + 8,  5'd1, 1'b0, 1'b1, 4'd0, 4'd1);
    push(c0 + 11, 5'd1, 1'b0, 1'b0, 4'd0, 4'd1);
    push(c0 + 12, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
    push(c0 + 13, 5'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(c0 + 16, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (sec_tick) ticks++;
    end
    chk("basic_tick_count", ticks, 3);
    wait_cyc(c0 + 17);

    // Zero load: done next cycle, ticks keep coming, count stays 0.
    do_load(5'd0, 1'b0, c0);
    push(c0,     5'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(c0 + 4, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
    push(c0 + 5, 5'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    push(c0 + 8, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(c0 + 9);

    // Pause for 5 cycles after load of 2: expiry moves from +8 to +13.
    do_load(5'd2, 1'b0, c0);
    push(c0,      5'd2, 1'b0, 1'b0, 4'd0, 4'd2);
    push(c0 + 4,  5'd2, 1'b0, 1'b0, 4'd0, 4'd2);
    push(c0 + 8,  5'd2, 1'b0, 1'b0, 4'd0, 4'd2);
    push(c0 + 9,  5'd1, 1'b0, 1'b1, 4'd0, 4'd1);
    push(c0 + 12, 5'd1, 1'b0, 1'b0, 4'd0, 4'd1);
    push(c0 + 13, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
    @(posedge clk); #1;
    pause = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    pause = 1'b0;

    // Load 28 on a would-be tick cycle with pause=1 and done=1.
    wait_cyc(c0 + 16);
    do_load(5'd28, 1'b1, c1);
    push(c1,     5'd28, 1'b0, 1'b0, 4'd2, 4'd8);
    push(c1 + 3, 5'd28, 1'b0, 1'b0, 4'd2, 4'd8);
    push(c1 + 7, 5'd27, 1'b0, 1'b1, 4'd2, 4'd7);
    wait_cyc(c1 + 3);
    pause = 1'b0;
    wait_cyc(c1 + 8);

    // Display boundaries, loaded back to back while paused.
    do_load(5'd31, 1'b1, c0); push(c0, 5'd31, 1'b0, 1'b0, 4'd3, 4'd1);
    do_load(5'd10, 1'b1, c0); push(c0, 5'd10, 1'b0, 1'b0, 4'd1, 4'd0);
    do_load(5'd9,  1'b1, c0); push(c0, 5'd9,  1'b0, 1'b0, 4'd0, 4'd9);
    do_load(5'd20, 1'b1, c0); push(c0, 5'd20, 1'b0, 1'b0, 4'd2, 4'd0);
    pause = 1'b0;
    wait_cyc(c0 + 2);

    // Asynchronous reset mid-count, away from any clock edge.
    do_load(5'd5, 1'b0, c0);
    wait_cyc(c0 + 6);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({remaining, cnt_done, sec_tick, bcd_tens, bcd_ones, seg_tens, seg_ones}),
        int'({5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 7'h3F}));
    push(c0 + 6, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    wait_cyc(c0 + 8);
    rst = 1'b1;
    rr  = c0 + 8;
    push(rr + 4, 5'd0, 1'b0, 1'b1, 4'd0, 4'd0);
    push(rr + 8, 5'd0, 1'b0, 1'b1, 4'd0, 4'd0);
    wait_cyc(rr + 9);

    // Closed loop: controller reloads on cnt_done through red/yellow/green.
    r0 = done_rises;
    for (int ph = 0; ph < 3; ph++) begin
      do_load(5'(durs[ph]), 1'b0, c0);
      push(c0 + 4 * durs[ph], 5'd0, 1'b1, 1'b1, 4'd0, 4'd0);
      ticks = 0;
      n     = 0;
      while (!cnt_done && n < 4 * durs[ph] + 10) begin
        @(posedge clk); #1;
        n++;
        if (sec_tick) ticks++;
      end
      chk("loop_phase_cycles", n, 4 * durs[ph]);
      chk("loop_phase_ticks", ticks, durs[ph]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("loop_done_rises", done_rises - r0, 3);

    // Drain the scoreboard.
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_leftover", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
